// File: rtl/mips32_pkg.sv
// Shared MIPS32 core definitions: response owner encoding, datapath width, HLT opcode.
// Combinational constants only; no timing or backpressure of its own.
package mips32_pkg;

  localparam int MIPS32_DATA_W = 32;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [5:0] OP_HLT = 6'b111111;

  typedef struct packed {
    logic vld;
    logic own;
  } rsp_tag_t;

endpackage

// File: rtl/mips32_rsp_tag_pipe.sv
// LAT-deep shift register of {valid, owner} tags that follows reads through the memory.
// Latency LAT cycles, one entry shifted in every cycle, never stalls.
module mips32_rsp_tag_pipe
  import mips32_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag,
  output rsp_tag_t head,
  output logic     any_vld
);

  rsp_tag_t stage [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < LAT; i++) any_vld = any_vld | stage[i].vld;
  end

  assign head = stage[LAT-1];

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port IF/MEM arbiter: data priority, bounded fetch starvation, halt blocks fetch.
// Grant is combinational, read data returns MEM_LAT cycles later; requesters hold req until gnt.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = MIPS32_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       if_win;
  rsp_tag_t   tag_in;
  rsp_tag_t   tag_out;
  logic       tag_busy;

  // Fetch only beats a data request once it has waited STARVE_MAX data grants.
  assign if_win = if_req & ~halt & (~dm_req | (starve_cnt == STARVE_LIM));
  assign if_gnt = rst_n & if_win;
  assign dm_gnt = rst_n & dm_req & ~if_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!halt) begin
      if (!if_req || if_gnt) starve_cnt <= '0;
      else if (dm_gnt)       starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = if_gnt ? if_addr : dm_addr;
  assign mem_wdata = dm_gnt ? dm_wdata : '0;

  // Stores occupy a slot but never produce a response.
  assign tag_in.vld = if_gnt | (dm_gnt & ~dm_we);
  assign tag_in.own = dm_gnt ? OWN_DM : OWN_IF;

  mips32_rsp_tag_pipe #(.LAT(MEM_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag     (tag_in),
    .head    (tag_out),
    .any_vld (tag_busy)
  );

  assign if_rvalid = tag_out.vld & (tag_out.own == OWN_IF);
  assign dm_rvalid = tag_out.vld & (tag_out.own == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  assign busy = if_req | dm_req | tag_busy;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter with a MEM_LAT-cycle memory model.
module tb_mips32_mem_arbiter;
  import mips32_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we, halt;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .halt      (halt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model: samples the access on the edge after the grant, data appears LAT cycles later.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_pipe [LAT];
  bit            preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'h2801000a + k;
      preloaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_pipe[0] <= mem[mem_addr];
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct {
    logic          own;
    logic [DW-1:0] dat;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [1024];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   glog = '0;
  int            gcnt = 0;
  int            g0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant order log, exclusivity, and in-order response checking against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_gnt || dm_gnt) begin
        check_eq("gnt_excl", 64'(if_gnt & dm_gnt), 64'd0);
        glog <= {glog[30:0], dm_gnt};
        gcnt <= gcnt + 1;
      end
      if (if_rvalid || dm_rvalid) begin
        check_eq("rvalid_excl", 64'(if_rvalid & dm_rvalid), 64'd0);
        if (sb.size() == 0) begin
          check_eq("unexp_rvalid", 64'(if_rvalid | dm_rvalid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("rsp_owner", 64'(dm_rvalid), 64'(mon_e.own));
          check_eq("rsp_data", 64'(dm_rvalid ? dm_rdata : if_rdata), 64'(mon_e.dat));
          check_eq("rsp_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end
    end
  end

  task automatic do_if_seq(input logic [AW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      if_req  = 1'b1;
      if_addr = base + AW'(k);
      @(negedge clk);
      while (!if_gnt && w < 100) begin
        w++;
        @(negedge clk);
      end
      if (!if_gnt) begin
        check_eq("if_gnt_timeout", 64'(if_gnt), 64'd1);
      end else begin
        check_eq("if_mem_addr", 64'(mem_addr), 64'(if_addr));
        check_eq("if_mem_we", 64'(mem_we), 64'd0);
        check_eq("if_mem_wdata", 64'(mem_wdata), 64'd0);
        sb.push_back('{OWN_IF, ref_mem[if_addr], cyc + LAT});
      end
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
  endtask

  task automatic do_dm_seq(input logic we, input logic [AW-1:0] base, input logic [DW-1:0] wd, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = base + AW'(k);
      dm_wdata = wd;
      @(negedge clk);
      while (!dm_gnt && w < 100) begin
        w++;
        @(negedge clk);
      end
      if (!dm_gnt) begin
        check_eq("dm_gnt_timeout", 64'(dm_gnt), 64'd1);
      end else begin
        check_eq("dm_mem_addr", 64'(mem_addr), 64'(dm_addr));
        check_eq("dm_mem_we", 64'(mem_we), 64'(we));
        check_eq("dm_mem_wdata", 64'(mem_wdata), 64'(wd));
        if (we) ref_mem[dm_addr] = wd;
        else    sb.push_back('{OWN_DM, ref_mem[dm_addr], cyc + LAT});
      end
      @(posedge clk);
      #1;
    end
    dm_req = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
    check_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 1024; k++) ref_mem[k] = 32'h2801000a + k;
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; halt = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;

    @(negedge clk);
    check_eq("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
    check_eq("rst_mem_en", 64'(mem_en), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back fetches of words 0..3.
    g0 = gcnt;
    do_if_seq(10'd0, 4);
    drain();
    check_eq("fetch_gnt_cnt", 64'(gcnt - g0), 64'd4);

    // Continuous contention: DDDDF repeating.
    g0 = gcnt;
    fork
      do_if_seq(10'd16, 2);
      do_dm_seq(1'b0, 10'd32, '0, 8);
    join
    drain();
    check_eq("contend_pattern", 64'(glog & ((32'd1 << (gcnt - g0)) - 1)), 64'b1111011110);

    // Store then load to the same word.
    do_dm_seq(1'b1, 10'd5, 32'hdeadbeef, 1);
    do_dm_seq(1'b0, 10'd5, '0, 1);
    drain();

    // Halt: earlier fetch completes, no fetch grant, data served, starvation count held.
    do_if_seq(10'd1, 1);
    halt = 1'b1;
    g0 = gcnt;
    fork
      do_if_seq(10'd2, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          check_eq("halt_if_gnt", 64'(if_gnt), 64'd0);
        end
        @(posedge clk);
        #1;
        do_dm_seq(1'b0, 10'd40, '0, 1);
        halt = 1'b0;
        do_dm_seq(1'b0, 10'd41, '0, 5);
      end
    join
    drain();
    check_eq("halt_pattern", 64'(glog & ((32'd1 << (gcnt - g0)) - 1)), 64'b1111101);

    // Reset with two reads in flight: their responses must never appear.
    do_if_seq(10'd100, 2);
    rst_n = 1'b0;
    sb.delete();
    if_req = 1'b1;
    @(negedge clk);
    check_eq("rst_hold_if_gnt", 64'(if_gnt), 64'd0);
    check_eq("rst_hold_mem_en", 64'(mem_en), 64'd0);
    check_eq("rst_hold_if_rvalid", 64'(if_rvalid), 64'd0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    repeat (LAT + 2) @(negedge clk);
    @(posedge clk);
    #1;

    // Interleaved F, D, F reads on consecutive cycles.
    do_if_seq(10'd200, 1);
    do_dm_seq(1'b0, 10'd201, '0, 1);
    do_if_seq(10'd202, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
